conv_wmst_master: RTL
=====================

Name: conv_wmst_master

Overview:
- Avalon-MM write master; the responder end of the wmst_ctrl_* / wmst_user_* interface that the conv write-memory stage drives.
- Accepts result words from the conv datapath into a FIFO.
- On ctrl_go, streams ctrl_write_length bytes from ctrl_write_base onto the system bus, one DW-bit beat per accepted bus write.
- Sits between the conv top level and the SoC interconnect; one instance per write port.

Parameters:
- AW, 30, byte-address and length width.
- DW, 128, data width; bytes per word BPW = DW/8.
- FD, 32, FIFO depth in words; power of two, at least 4.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-low.
- ctrl_fixed_location  in  1  1 = address does not increment.
- ctrl_write_base  in  AW  start byte address; sampled on go.
- ctrl_write_length  in  AW  transfer length in bytes; sampled on go.
- ctrl_go  in  1  start pulse.
- ctrl_done  out  1  high while idle.
- user_write_buffer  in  1  push user_write_input_data into the FIFO.
- user_write_input_data  in  DW  result word.
- user_buffer_full  out  1  FIFO full; a push is illegal while this is high.
- master_address  out  AW  bus byte address.
- master_write  out  1  bus write request.
- master_byteenable  out  DW/8  always all ones.
- master_writedata  out  DW  FIFO head word.
- master_waitrequest  in  1  bus stall.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE; addr, remaining, fixed register all 0.
  - FIFO pointers and count = 0.
  - ctrl_done=1, master_write=0, user_buffer_full=0, master_address=0.
  - Reset in mid-transfer aborts the transfer and flushes the FIFO; no further bus writes are issued.
- FSM states: IDLE and RUN.
- IDLE:
  - ctrl_done=1.
  - On ctrl_go: addr<=ctrl_write_base, fixed<=ctrl_fixed_location.
  - remaining<=ctrl_write_length with the low log2(BPW) bits forced to 0 (length is rounded down to whole words).
  - If the rounded length is 0: stay in IDLE, no bus activity, ctrl_done stays 1.
  - Otherwise go to RUN on the next cycle.
- RUN:
  - ctrl_done=0.
  - ctrl_go is ignored.
  - master_write = (FIFO not empty); combinational from the registered state and count.
  - master_writedata = FIFO head, show-ahead.
  - master_address = addr.
  - A beat is accepted when master_write && !master_waitrequest. On acceptance:
    - pop the FIFO;
    - remaining -= BPW;
    - addr += BPW unless fixed, with AW-bit wrap-around at 2^AW.
  - When remaining==BPW and a beat is accepted, go to IDLE. ctrl_done rises the following cycle.
  - While master_waitrequest is high, address and data must be held stable.
- Latency: go at cycle N with the FIFO non-empty gives master_write=1 at cycle N+1.
- FIFO:
  - A push (user_write_buffer && !full) is accepted in any state.
  - Words pushed while IDLE wait for the next go.
  - Words in excess of the transfer length remain queued for the next transfer.
  - user_buffer_full = (count==FD), registered-count based.
  - A push while full is dropped, and count is unchanged.
  - Simultaneous push and pop: count is unchanged, and a push is allowed at count==FD only if full is low. Full is high at FD, so the push is refused.
  - Simultaneous push and pop on an empty FIFO cannot occur, because master_write is low when the FIFO is empty.
- Arithmetic: addr and remaining are AW bits, unsigned.
- ctrl_done is a level signal, not a pulse. The caller detects completion as a rising edge after go.

Decomposition:
- Shared package conv_mst_pkg:
  - BPW and byte-offset width;
  - state encoding (ST_IDLE, ST_RUN);
  - function clog2.
- One sub-module: conv_wmst_fifo, a synchronous show-ahead FIFO. Parameters DW and FD. Ports push, pop, din, dout, empty, full, count. Same clk and rst rules.
- The FSM and address counters stay in the top module.

Test Plan:
- Basic transfer (DW=128, BPW=16):
  - Stimulus: push 4 words D0..D3, then go with base=0x1000, length=64, fixed=0, waitrequest=0.
  - Required: writes at 0x1000, 0x1010, 0x1020, 0x1030 with D0..D3 on consecutive cycles; ctrl_done back to 1 one cycle after the 4th beat.
- Backpressure: same transfer, waitrequest high for 3 cycles on beat 2 -> address 0x1010 and D1 are held for 4 cycles, all 4 beats complete in order.
- Fixed location and late data:
  - Stimulus: fixed=1, length=48, empty FIFO at go, then 3 words pushed one every 2 cycles.
  - Required: 3 writes, all to base; master_write low while the FIFO is empty; done afterwards.
- Full/overflow:
  - Stimulus: push 32 words while IDLE, then a 33rd push.
  - Required: user_buffer_full=1 after the 32nd push; the 33rd word is absent; a 512-byte go writes exactly the 32 original words.
- Length edges:
  - length=0 -> no bus write, ctrl_done stays 1.
  - length=40 -> rounded down to 32, exactly 2 writes; the 3rd pushed word stays queued and is written first by the next go.
- Reset mid-transfer: rst=0 for 1 cycle after beat 2 of 4 -> master_write=0, ctrl_done=1, FIFO empty; no writes until a new go with new data.

Source files
------------

// File: rtl/conv_mst_pkg.sv
// Shared definitions for the conv write master: byte/word geometry, FSM
// state encoding and a constant-evaluable log2 helper.
package conv_mst_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    localparam int DEF_DW = 128;
    localparam int BPW    = DEF_DW / 8;
    localparam int OFS_W  = clog2(BPW);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/conv_wmst_fifo.sv
// Synchronous show-ahead FIFO: dout always presents the oldest word.
// Pushes while full and pops while empty are ignored.
module conv_wmst_fifo #(
    parameter int DW = 128,
    parameter int FD = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  logic [DW-1:0]                    din,
    output logic [DW-1:0]                    dout,
    output logic                             empty,
    output logic                             full,
    output logic [conv_mst_pkg::clog2(FD):0] count
);
    import conv_mst_pkg::*;

    localparam int PW = clog2(FD);

    logic [DW-1:0] mem [FD];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == (PW+1)'(FD));
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)
                count <= count + 1'b1;
            else if (!push_ok && pop_ok)
                count <= count - 1'b1;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/conv_wmst_master.sv
// Avalon-MM write master: queues result words and streams a whole number
// of words to the bus after each go.
//
//   state   | meaning
//   --------+--------------------------------------------------------
//   ST_IDLE | done high, waiting for go with a non-zero word length
//   ST_RUN  | issuing one write per FIFO word until length is spent
module conv_wmst_master #(
    parameter int AW = 30,
    parameter int DW = 128,
    parameter int FD = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ctrl_fixed_location,
    input  logic [AW-1:0]   ctrl_write_base,
    input  logic [AW-1:0]   ctrl_write_length,
    input  logic            ctrl_go,
    output logic            ctrl_done,
    input  logic            user_write_buffer,
    input  logic [DW-1:0]   user_write_input_data,
    output logic            user_buffer_full,
    output logic [AW-1:0]   master_address,
    output logic            master_write,
    output logic [DW/8-1:0] master_byteenable,
    output logic [DW-1:0]   master_writedata,
    input  logic            master_waitrequest
);
    import conv_mst_pkg::*;

    localparam int BYTES = DW / 8;
    localparam int CW    = clog2(FD) + 1;

    state_t        state;
    logic [AW-1:0] addr;
    logic [AW-1:0] remaining;
    logic          fixed;
    logic [AW-1:0] go_len;
    logic          accept;
    logic          fifo_empty;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;

    // Partial trailing words are never written.
    assign go_len = ctrl_write_length & ~AW'(BYTES - 1);

    assign master_write      = (state == ST_RUN) && (fifo_count != '0);
    assign accept            = master_write && !master_waitrequest;
    assign master_address    = addr;
    assign master_byteenable = '1;
    assign ctrl_done         = (state == ST_IDLE);
    assign user_buffer_full  = fifo_full;

    conv_wmst_fifo #(
        .DW (DW),
        .FD (FD)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (user_write_buffer),
        .pop   (accept && !fifo_empty),
        .din   (user_write_input_data),
        .dout  (master_writedata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            remaining <= '0;
            fixed     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (ctrl_go) begin
                        addr      <= ctrl_write_base;
                        fixed     <= ctrl_fixed_location;
                        remaining <= go_len;
                        if (go_len != '0) state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        remaining <= remaining - AW'(BYTES);
                        if (!fixed) addr <= addr + AW'(BYTES);
                        if (remaining == AW'(BYTES)) state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
